muldiv_sequencer: RTL and testbench

- Sequences the shared multiplier and divider units on behalf of the main control FSM.
- Accepts one MULT/DIV request at a time and pulses the start line of the selected unit. Waits for that unit's end flag, then issues a single HI/LO write with the correct source select.
- Raises divide-by-zero and timeout exceptions; supports abort from the control unit.
- Sits between ctrl_unit and the mult/div units plus the HI/LO mux and register pair.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_timeout_cnt.sv | 30 +++
 rtl/muldiv_sequencer.sv | 99 +++++++++
 tb/tb_muldiv_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer and its timeout counter.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic OP_MULT       = 1'b0;
  localparam logic OP_DIV        = 1'b1;
  localparam logic HILO_SEL_MULT = 1'b0;
  localparam logic HILO_SEL_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_timeout_cnt.sv
// Wait-cycle counter for the sequencer; expire is high while the count sits at
// TIMEOUT_CYCLES-1.
module muldiv_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV request through the shared units and commits a single
// HI/LO write, or raises a divide-by-zero / timeout exception.
//
//   state | meaning
//   IDLE  | ready for a request
//   START | one-cycle start pulse to the selected unit
//   WAIT  | counting cycles until the selected unit's end flag
//   WRITE | one-cycle HI/LO write and done pulse
//   ERR   | one-cycle divide-by-zero pulse
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] divisor,
  input  logic        abort,
  output logic        req_ready,
  output logic        busy,
  output logic        mult_start,
  output logic        div_start,
  input  logic        mult_end,
  input  logic        div_end,
  input  logic        div_zero,
  output logic        hilo_write,
  output logic        hilo_sel,
  output logic        done,
  output logic        div0_exc,
  output logic        timeout_exc
);

  state_t state;
  logic   opQ;
  logic   timeoutQ;
  logic   cntExpire;
  logic   selEnd;

  muldiv_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) uTimeoutCnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state != WAIT),
    .en    (state == WAIT),
    .expire(cntExpire)
  );

  assign selEnd = (opQ == OP_DIV) ? div_end : mult_end;

  // Priority in START/WAIT: abort, then the unit's end flag, then timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      opQ      <= OP_MULT;
      timeoutQ <= 1'b0;
    end else begin
      timeoutQ <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            opQ   <= req_op;
            state <= (req_op == OP_DIV && divisor == 32'd0) ? ERR : START;
          end
        end
        START, WAIT: begin
          if (abort) begin
            state <= IDLE;
          end else if (selEnd) begin
            state <= (opQ == OP_DIV && div_zero) ? ERR : WRITE;
          end else if (state == WAIT && cntExpire) begin
            state    <= IDLE;
            timeoutQ <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WRITE, ERR: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Timeout is flagged on the transition, so its pulse lands in the first IDLE cycle.
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign mult_start  = (state == START) && (opQ == OP_MULT);
  assign div_start   = (state == START) && (opQ == OP_DIV);
  assign hilo_write  = (state == WRITE);
  assign done        = (state == WRITE);
  assign div0_exc    = (state == ERR);
  assign timeout_exc = timeoutQ;
  assign hilo_sel    = (state != IDLE && opQ == OP_DIV) ? HILO_SEL_DIV : HILO_SEL_MULT;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, reset corner cases and
// random requests, each checked cycle-by-cycle against a timeline model.
module tb_muldiv_sequencer;

  localparam int TIMEOUT = 64;
  localparam int TO_CYC  = 1 + TIMEOUT;  // cycle (1 = START) whose edge expires the wait
  localparam logic [8:0] V_IDLE = 9'b1_0000_0000;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_op, abort;
  logic [31:0] divisor;
  logic        mult_end, div_end, div_zero;
  logic        req_ready, busy, mult_start, div_start;
  logic        hilo_write, hilo_sel, done, div0_exc, timeout_exc;
  logic [8:0]  outVec;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .divisor(divisor), .abort(abort), .req_ready(req_ready), .busy(busy),
    .mult_start(mult_start), .div_start(div_start), .mult_end(mult_end),
    .div_end(div_end), .div_zero(div_zero), .hilo_write(hilo_write),
    .hilo_sel(hilo_sel), .done(done), .div0_exc(div0_exc),
    .timeout_exc(timeout_exc)
  );

  always #5 clk = ~clk;

  assign outVec = {req_ready, busy, mult_start, div_start, hilo_write,
                   hilo_sel, done, div0_exc, timeout_exc};

  typedef struct {
    string       nm;
    bit          op;
    logic [31:0] dvs;
    int          endCyc;    // cycle the selected unit raises its end flag (0 = never)
    bit          zf;
    int          abortCyc;  // 0 = no abort
    int          otherCyc;  // cycle the non-selected unit raises its end flag
    int          expKind;   // 0 none, 1 done, 2 div0, 3 timeout
    int          expCyc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int k, input logic [8:0] got, input logic [8:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d outputs got=%b want=%b", nm, k, got, want);
    end
  endtask

  task automatic chkEv(input string nm, input int gotK, input int gotC, input int wantK, input int wantC);
    total++;
    if (gotK != wantK || gotC != wantC) begin
      bad++;
      $display("FAIL %s event got kind=%0d cyc=%0d want kind=%0d cyc=%0d", nm, gotK, gotC, wantK, wantC);
    end
  endtask

  // Cycle 1 is the cycle after the accept edge. The model builds the expected
  // output vector for every cycle from the outcome rules, then the run is
  // replayed against it.
  task automatic runOp(input string nm, input bit op, input logic [31:0] dvs,
                       input int endCyc, input bit zf, input int abortCyc,
                       input int otherCyc, output int obsKind, output int obsCyc);
    logic [8:0] want[$];
    logic [8:0] vStart, vWait, vWrite, vErr, vTo;
    int tEnd, tAb;
    vStart = {1'b0, 1'b1, ~op, op, 1'b0, op, 3'b000};
    vWait  = {1'b0, 1'b1, 2'b00, 1'b0, op, 3'b000};
    vWrite = {1'b0, 1'b1, 2'b00, 1'b1, op, 1'b1, 2'b00};
    vErr   = {1'b0, 1'b1, 2'b00, 1'b0, op, 1'b0, 1'b1, 1'b0};
    vTo    = 9'b1_0000_0001;
    tEnd = (endCyc >= 1) ? endCyc : 1000;
    tAb  = (abortCyc >= 1) ? abortCyc : 1000;
    if (op && dvs == 32'd0) begin
      want.push_back(vErr);
    end else begin
      want.push_back(vStart);
      if (tAb <= tEnd && tAb <= TO_CYC) begin
        for (int k = 2; k <= tAb; k++) want.push_back(vWait);
      end else if (tEnd <= TO_CYC) begin
        for (int k = 2; k <= tEnd; k++) want.push_back(vWait);
        want.push_back((op && zf) ? vErr : vWrite);
      end else begin
        for (int k = 2; k <= TO_CYC; k++) want.push_back(vWait);
        want.push_back(vTo);
      end
    end
    want.push_back(V_IDLE);

    req_valid = 1'b1; req_op = op; divisor = dvs;
    abort = 1'b0; mult_end = 1'b0; div_end = 1'b0; div_zero = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 1'($urandom); divisor = $urandom;
    obsKind = 0; obsCyc = 0;
    for (int k = 1; k <= want.size(); k++) begin
      abort    = (k == abortCyc);
      mult_end = (!op && k == endCyc) || (op && k == otherCyc);
      div_end  = (op && k == endCyc) || (!op && k == otherCyc);
      div_zero = op && (k == endCyc) && zf;
      @(negedge clk);
      chk(nm, k, outVec, want[k-1]);
      if (obsKind == 0) begin
        if (done)             begin obsKind = 1; obsCyc = k; end
        else if (div0_exc)    begin obsKind = 2; obsCyc = k; end
        else if (timeout_exc) begin obsKind = 3; obsCyc = k; end
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; mult_end = 1'b0; div_end = 1'b0; div_zero = 1'b0;
  endtask

  initial begin
    int oK, oC;
    tbl.push_back('{"mult_basic",     1'b0, 32'd5,  33, 1'b0,  0,  0, 1, 34});
    tbl.push_back('{"div_basic",      1'b1, 32'd7,  33, 1'b0,  0, 10, 1, 34});
    tbl.push_back('{"div_precheck",   1'b1, 32'd0,   0, 1'b0,  0,  0, 2,  1});
    tbl.push_back('{"timeout",        1'b0, 32'd5,  66, 1'b0,  0,  0, 3, 66});
    tbl.push_back('{"abort_wait",     1'b0, 32'd9,  40, 1'b0, 12,  0, 0,  0});
    tbl.push_back('{"after_abort",    1'b0, 32'd9,   5, 1'b0,  0,  0, 1,  6});
    tbl.push_back('{"div_zero_flag",  1'b1, 32'd3,  20, 1'b1,  0,  0, 2, 21});
    tbl.push_back('{"end_in_start",   1'b0, 32'd2,   1, 1'b0,  0,  0, 1,  2});
    tbl.push_back('{"end_vs_timeout", 1'b1, 32'd11, 65, 1'b0,  0,  0, 1, 66});
    tbl.push_back('{"abort_in_write", 1'b0, 32'd8,  10, 1'b0, 11,  0, 1, 11});
    tbl.push_back('{"abort_in_err",   1'b1, 32'd0,   0, 1'b0,  1,  0, 2,  1});
    tbl.push_back('{"abort_in_start", 1'b1, 32'd4,  30, 1'b0,  1,  0, 0,  0});
    tbl.push_back('{"other_unit_only",1'b1, 32'd4,   0, 1'b0,  0, 20, 3, 66});

    reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; divisor = '0;
    abort = 1'b0; mult_end = 1'b0; div_end = 1'b0; div_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 0, outVec, V_IDLE);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (tbl[i]) begin
      runOp(tbl[i].nm, tbl[i].op, tbl[i].dvs, tbl[i].endCyc, tbl[i].zf,
            tbl[i].abortCyc, tbl[i].otherCyc, oK, oC);
      chkEv(tbl[i].nm, oK, oC, tbl[i].expKind, tbl[i].expCyc);
    end

    // Reset in WAIT with the unit's end flag arriving on the same edge.
    req_valid = 1'b1; req_op = 1'b0; divisor = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b0; mult_end = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_mid_op", 0, outVec, V_IDLE);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_after", 1, outVec, V_IDLE);
    @(posedge clk); #1;
    mult_end = 1'b0;
    runOp("after_reset", 1'b0, 32'd1, 12, 1'b0, 0, 0, oK, oC);
    chkEv("after_reset", oK, oC, 1, 13);

    for (int n = 0; n < 30; n++) begin
      bit          rop;
      logic [31:0] rdvs;
      int          rEnd, rAb, rOth;
      rop  = 1'($urandom);
      rdvs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rEnd = $urandom_range(0, 70);
      rAb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 70) : 0;
      rOth = $urandom_range(0, 70);
      runOp("random", rop, rdvs, rEnd, 1'($urandom), rAb, rOth, oK, oC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
